// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer with compare match, auto-reload and level interrupt.
// Optional prescaler is built only when MMIO_TIMER_PRESCALE_EN is defined.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        hit,
    output logic        irq
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_COMPARE  = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    logic [2:0]  sel;
    logic        wr_en;
    logic        wr_ctrl;
    logic        wr_prescale;
    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;

    logic        ctrl_en;
    logic        ctrl_auto;
    logic        ctrl_irq_en;
    logic [31:0] count;
    logic [31:0] compare;
    logic        match;

    logic        tick;
    logic        count_eq;
    logic        match_set;
    logic [15:0] prescale_rd;
    logic        unused_addr_lsbs;

    // Byte lanes are ignored: every register is a full word.
    assign unused_addr_lsbs = ^addr[1:0];

    assign hit         = (addr[31:5] == BASE_ADDR[31:5]);
    assign sel         = addr[4:2];
    assign wr_en       = we & hit;
    assign wr_ctrl     = wr_en & (sel == OFF_CTRL);
    assign wr_prescale = wr_en & (sel == OFF_PRESCALE);
    assign wr_count    = wr_en & (sel == OFF_COUNT);
    assign wr_compare  = wr_en & (sel == OFF_COMPARE);
    assign wr_status   = wr_en & (sel == OFF_STATUS);

`ifdef MMIO_TIMER_PRESCALE_EN
    logic [15:0] prescale;
    logic [15:0] presc_cnt;
    logic        presc_wrap;

    assign presc_wrap  = (presc_cnt == prescale);
    assign tick        = ctrl_en & presc_wrap;
    assign prescale_rd = prescale;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale <= 16'h0;
        end else if (wr_prescale) begin
            prescale <= wd[15:0];
        end
    end

    // A PRESCALE write restarts the divider so the new period starts cleanly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_cnt <= 16'h0;
        end else if (wr_prescale) begin
            presc_cnt <= 16'h0;
        end else if (ctrl_en) begin
            presc_cnt <= presc_wrap ? 16'h0 : presc_cnt + 16'h1;
        end
    end
`else
    logic unused_wr_prescale;

    assign unused_wr_prescale = wr_prescale;
    assign tick               = ctrl_en;
    assign prescale_rd        = 16'h0;
`endif

    assign count_eq  = (count == compare);
    assign match_set = tick & count_eq;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_en     <= 1'b0;
            ctrl_auto   <= 1'b0;
            ctrl_irq_en <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_en     <= wd[0];
            ctrl_auto   <= wd[1];
            ctrl_irq_en <= wd[2];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            compare <= 32'hFFFF_FFFF;
        end else if (wr_compare) begin
            compare <= wd;
        end
    end

    // Bus write beats the tick; increment wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 32'h0;
        end else if (wr_count) begin
            count <= wd;
        end else if (tick) begin
            count <= (count_eq && ctrl_auto) ? 32'h0 : count + 32'h1;
        end
    end

    // Set dominates a coincident write-1-to-clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match <= 1'b0;
        end else if (match_set) begin
            match <= 1'b1;
        end else if (wr_status && wd[0]) begin
            match <= 1'b0;
        end
    end

    assign irq = match & ctrl_irq_en;

    always_comb begin
        rd = 32'h0;
        if (hit) begin
            case (sel)
                OFF_CTRL:     rd = {29'h0, ctrl_irq_en, ctrl_auto, ctrl_en};
                OFF_PRESCALE: rd = {16'h0, prescale_rd};
                OFF_COUNT:    rd = count;
                OFF_COMPARE:  rd = compare;
                OFF_STATUS:   rd = {31'h0, match};
                default:      rd = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed self-checking bench for mmio_timer; expectations follow the
// prescaler build option so the bench works with or without the macro.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_0100;
`ifdef MMIO_TIMER_PRESCALE_EN
    localparam bit PS_ON = 1'b1;
`else
    localparam bit PS_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        hit;
    logic        irq;

    int checks;
    int failures;

    mmio_timer #(.BASE_ADDR(BASE)) dut (
        .clk  (clk),
        .reset(reset),
        .we   (we),
        .addr (addr),
        .wd   (wd),
        .rd   (rd),
        .hit  (hit),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Write lands on the next rising edge; returns 1ns after it.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        we   = 1'b1;
        addr = a;
        wd   = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd_reg(input int off, output logic [31:0] v);
        addr = BASE + 32'(off * 4);
        #1;
        v = rd;
    endtask

    task automatic do_reset();
        we    = 1'b0;
        reset = 1'b0;
        #3;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] exp_v [5];
        exp_v = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rd_reg(i, v);
            checks++;
            if (v !== exp_v[i]) begin
                failures++;
                $display("FAIL reset_off%0d: got %h expected %h", i, v, exp_v[i]);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_prescale();
        logic [31:0] v;
        logic [31:0] exp_v;
        do_reset();
        bus_write(BASE + 32'h4, 32'h3);
        rd_reg(1, v);
        exp_v = PS_ON ? 32'h3 : 32'h0;
        checks++;
        if (v !== exp_v) begin
            failures++;
            $display("FAIL prescale_readback: got %h expected %h", v, exp_v);
        end
        bus_write(BASE + 32'h0, 32'h1);
        repeat (19) @(posedge clk);
        rd_reg(2, v);
        exp_v = PS_ON ? 32'd4 : 32'd19;
        checks++;
        if (v !== exp_v) begin
            failures++;
            $display("FAIL prescale_count19: got %0d expected %0d", v, exp_v);
        end
        @(posedge clk);
        rd_reg(2, v);
        exp_v = PS_ON ? 32'd5 : 32'd20;
        checks++;
        if (v !== exp_v) begin
            failures++;
            $display("FAIL prescale_count20: got %0d expected %0d", v, exp_v);
        end
        bus_write(BASE + 32'h0, 32'h0);
        repeat (5) @(posedge clk);
        rd_reg(2, v);
        exp_v = PS_ON ? 32'd5 : 32'd21;
        checks++;
        if (v !== exp_v) begin
            failures++;
            $display("FAIL disabled_hold: got %0d expected %0d", v, exp_v);
        end
    endtask

    task automatic test_autoreload();
        logic [31:0] v;
        logic [31:0] seq [5];
        seq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
        do_reset();
        bus_write(BASE + 32'h4, 32'h0);
        bus_write(BASE + 32'hC, 32'h4);
        bus_write(BASE + 32'h0, 32'h7);
        rd_reg(2, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL autoreload_start: got %0d expected 0", v);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            rd_reg(2, v);
            checks++;
            if (v !== seq[k]) begin
                failures++;
                $display("FAIL autoreload_seq%0d: got %0d expected %0d", k, v, seq[k]);
            end
            checks++;
            if (irq !== (k == 4)) begin
                failures++;
                $display("FAIL autoreload_irq%0d: got %b expected %b", k, irq, (k == 4));
            end
        end
        rd_reg(4, v);
        checks++;
        if (v !== 32'h1) begin
            failures++;
            $display("FAIL autoreload_match: got %h expected 1", v);
        end
        bus_write(BASE + 32'h10, 32'h1);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL w1c_irq_drop: got %b expected 0", irq);
        end
        rd_reg(4, v);
        checks++;
        if (v !== 32'h0) begin
            failures++;
            $display("FAIL w1c_status: got %h expected 0", v);
        end
        bus_write(BASE + 32'h0, 32'h0);
    endtask

    task automatic test_wrap_priority();
        logic [31:0] v;
        do_reset();
        bus_write(BASE + 32'h8, 32'hFFFF_FFFF);
        bus_write(BASE + 32'h0, 32'h1);
        @(posedge clk);
        rd_reg(2, v);
        checks++;
        if (v !== 32'h0) begin
            failures++;
            $display("FAIL wrap: got %h expected 0", v);
        end
        bus_write(BASE + 32'h8, 32'h0000_1234);
        rd_reg(2, v);
        checks++;
        if (v !== 32'h0000_1234) begin
            failures++;
            $display("FAIL write_priority: got %h expected 00001234", v);
        end
        @(posedge clk);
        rd_reg(2, v);
        checks++;
        if (v !== 32'h0000_1235) begin
            failures++;
            $display("FAIL count_after_write: got %h expected 00001235", v);
        end
        // Collide W1C with the match edge.
        bus_write(BASE + 32'h0, 32'h0);
        bus_write(BASE + 32'hC, 32'd12);
        bus_write(BASE + 32'h8, 32'd10);
        bus_write(BASE + 32'h0, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        bus_write(BASE + 32'h10, 32'h1);
        rd_reg(4, v);
        checks++;
        if (v !== 32'h1) begin
            failures++;
            $display("FAIL set_beats_w1c: got %h expected 1", v);
        end
        rd_reg(2, v);
        checks++;
        if (v !== 32'd13) begin
            failures++;
            $display("FAIL no_reload_increment: got %0d expected 13", v);
        end
        bus_write(BASE + 32'h0, 32'h0);
        bus_write(BASE + 32'h10, 32'h1);
        rd_reg(4, v);
        checks++;
        if (v !== 32'h0) begin
            failures++;
            $display("FAIL w1c_plain: got %h expected 0", v);
        end
    endtask

    task automatic test_decode();
        logic [31:0] v;
        int          ps;
        do_reset();
        we   = 1'b1;
        addr = BASE + 32'd32;
        wd   = 32'h7;
        #1;
        checks++;
        if (hit !== 1'b0 || rd !== 32'h0) begin
            failures++;
            $display("FAIL decode_outside: hit=%b rd=%h expected hit=0 rd=0", hit, rd);
        end
        @(posedge clk);
        #1;
        we = 1'b0;
        rd_reg(0, v);
        checks++;
        if (v !== 32'h0) begin
            failures++;
            $display("FAIL decode_no_write: got %h expected 0", v);
        end
        addr = BASE - 32'd4;
        #1;
        checks++;
        if (hit !== 1'b0) begin
            failures++;
            $display("FAIL decode_below: hit=%b expected 0", hit);
        end
        bus_write(BASE + 32'd24, 32'hDEAD_BEEF);
        rd_reg(6, v);
        checks++;
        if (v !== 32'h0 || hit !== 1'b1) begin
            failures++;
            $display("FAIL decode_off6: rd=%h hit=%b expected rd=0 hit=1", v, hit);
        end
        // Asynchronous reset in the middle of a count.
        bus_write(BASE + 32'h0, 32'h1);
        repeat (3) @(posedge clk);
        rd_reg(2, v);
        checks++;
        if (v !== 32'd3) begin
            failures++;
            $display("FAIL midcount_pre: got %0d expected 3", v);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL async_reset_count: got %h expected 0", rd);
        end
        #1;
        reset = 1'b1;
        ps = PS_ON ? 2 : 0;
        bus_write(BASE + 32'h4, 32'h2);
        bus_write(BASE + 32'h0, 32'h1);
        repeat (ps) @(posedge clk);
        rd_reg(2, v);
        checks++;
        if (v !== 32'h0) begin
            failures++;
            $display("FAIL first_tick_early: got %0d expected 0", v);
        end
        @(posedge clk);
        rd_reg(2, v);
        checks++;
        if (v !== 32'h1) begin
            failures++;
            $display("FAIL first_tick: got %0d expected 1", v);
        end
        bus_write(BASE + 32'h0, 32'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        we       = 1'b0;
        addr     = 32'h0;
        wd       = 32'h0;
        #12;
        test_reset();
        test_prescale();
        test_autoreload();
        test_wrap_priority();
        test_decode();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
